// File: rtl/alu_op_cycler.sv
// Push-button ALU: each debounced press executes op_sel on the operands and advances op_sel.
// Define ALU_MUL_EN to add op 8 (iterative shift-add multiply) and its MUL state.
module alu_op_cycler #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic [WIDTH-1:0] number_1,
  input  logic [WIDTH-1:0] number_2,
  output logic [WIDTH:0]   answer,
  output logic [3:0]       op_sel,
  output logic             valid,
  output logic             busy,
  output logic             zero,
  output logic             ovf
);

  // state  | meaning
  // S_IDLE | waiting for a press; operands and op captured on press
  // S_EXEC | single-cycle ALU op (0-7); result registered on exit
  // S_MUL  | shift-add multiply, WIDTH steps then one write-back cycle

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);
`ifdef ALU_MUL_EN
  localparam logic [3:0] LAST_OP = 4'd8;
  localparam int MC_W = $clog2(WIDTH + 1);
`else
  localparam logic [3:0] LAST_OP = 4'd7;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1
`ifdef ALU_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_t;

  state_t state, state_nxt;

  logic            sync_ff1, sync_ff2;
  logic            db_level, db_level_q;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  logic [WIDTH-1:0] op_a, op_b;
  logic [3:0]       op_q;
  logic [WIDTH:0]   alu_res;
  logic [3:0]       next_op;
  logic             capture, exec_done, mul_step, mul_done;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [MC_W-1:0]    mul_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff1   <= 1'b0;
      sync_ff2   <= 1'b0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync_ff1   <= button;
      sync_ff2   <= sync_ff1;
      db_level_q <= db_level;
      // Any sample matching the current level restarts the stability count.
      if (sync_ff2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TC) begin
        db_level <= sync_ff2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press   = db_level & ~db_level_q;
  assign busy    = (state != S_IDLE);
  assign next_op = (op_sel == LAST_OP) ? 4'd0 : op_sel + 4'd1;

  always_comb begin
    alu_res = '0;
    case (op_q)
      4'd0:    alu_res = {1'b0, op_a} + {1'b0, op_b};
      4'd1:    alu_res = {1'b0, op_a} - {1'b0, op_b};
      4'd2:    alu_res = {1'b0, op_a & op_b};
      4'd3:    alu_res = {1'b0, op_a | op_b};
      4'd4:    alu_res = {1'b0, op_a ^ op_b};
      4'd5:    alu_res = {1'b0, ~op_a};
      4'd6:    alu_res = {op_a, 1'b0};
      4'd7:    alu_res = {2'b00, op_a[WIDTH-1:1]};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    exec_done = 1'b0;
    mul_step  = 1'b0;
    mul_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (press) begin
          capture = 1'b1;
`ifdef ALU_MUL_EN
          state_nxt = (op_sel == 4'd8) ? S_MUL : S_EXEC;
`else
          state_nxt = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        exec_done = 1'b1;
        state_nxt = S_IDLE;
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (mul_cnt != '0) begin
          mul_step = 1'b1;
        end else begin
          mul_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      answer <= '0;
      op_sel <= 4'd0;
      valid  <= 1'b0;
      zero   <= 1'b1;
      op_a   <= '0;
      op_b   <= '0;
      op_q   <= 4'd0;
    end else begin
      valid <= 1'b0;
      if (capture) begin
        op_a <= number_1;
        op_b <= number_2;
        op_q <= op_sel;
      end
      if (exec_done) begin
        answer <= alu_res;
        zero   <= (alu_res == '0);
        valid  <= 1'b1;
        op_sel <= next_op;
      end
`ifdef ALU_MUL_EN
      if (mul_done) begin
        answer <= acc[WIDTH:0];
        zero   <= (acc[WIDTH:0] == '0);
        valid  <= 1'b1;
        op_sel <= next_op;
      end
`endif
    end
  end

`ifdef ALU_MUL_EN
  // Multiplier regs load on every capture; harmless for ops 0-7.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mul_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (capture) begin
        acc     <= '0;
        mcand   <= {{WIDTH{1'b0}}, number_1};
        mplier  <= number_2;
        mul_cnt <= MC_W'(WIDTH);
      end else if (mul_step) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt - 1'b1;
      end
      if (exec_done)     ovf <= 1'b0;
      else if (mul_done) ovf <= |acc[2*WIDTH-1:WIDTH+1];
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_cycler.sv
// Directed bench for alu_op_cycler (WIDTH=8, DEBOUNCE_CYCLES=4); MUL steps run when ALU_MUL_EN is defined.
module tb_alu_op_cycler;
  logic       clk = 1'b0;
  logic       reset, button;
  logic [7:0] number_1, number_2;
  logic [8:0] answer;
  logic [3:0] op_sel;
  logic       valid, busy, zero, ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int valid_count = 0;
  int busy_count  = 0;

  alu_op_cycler #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .button(button),
    .number_1(number_1), .number_2(number_2),
    .answer(answer), .op_sel(op_sel), .valid(valid),
    .busy(busy), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) valid_count++;
    if (busy)  busy_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [8:0] ans, input logic z,
                           input logic o, input logic [3:0] op);
    check({tag, "_answer"}, answer, ans);
    check({tag, "_zero"}, zero, z);
    check({tag, "_ovf"}, ovf, o);
    check({tag, "_op_sel"}, op_sel, op);
  endtask

  // Press for 'hold' cycles, expect valid 'exp_lat' negedges after the button rises.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input int exp_lat);
    int v0, lat;
    logic got;
    v0 = valid_count;
    lat = 0;
    got = 1'b0;
    number_1 = a;
    number_2 = b;
    @(negedge clk);
    button = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == hold) button = 1'b0;
      if (valid && !got) begin
        got = 1'b1;
        lat = i;
      end
      if (got && i >= hold) break;
    end
    button = 1'b0;
    check({tag, "_valid_seen"}, got, 1);
    check({tag, "_latency"}, lat, exp_lat);
    repeat (14) @(negedge clk);
    check({tag, "_one_valid"}, valid_count - v0, 1);
  endtask

  task automatic glitch(input int n);
    @(negedge clk);
    button = 1'b1;
    repeat (n) @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int v0, b0;
    reset = 1'b1;
    button = 1'b0;
    number_1 = 8'h00;
    number_2 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_answer", answer, 9'h000);
    check("rst_op_sel", op_sel, 4'd0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_zero", zero, 1'b1);
    check("rst_ovf", ovf, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op("add", 8'h0A, 8'h02, 4, 8);
    check_out("add", 9'h00C, 1'b0, 1'b0, 4'd1);
    run_op("sub", 8'h02, 8'h0A, 4, 8);
    check_out("sub", 9'h1F8, 1'b0, 1'b0, 4'd2);

    v0 = valid_count;
    glitch(1);
    glitch(2);
    glitch(3);
    check("glitch_no_valid", valid_count - v0, 0);
    check("glitch_op_sel", op_sel, 4'd2);

    run_op("and", 8'hF0, 8'h3C, 10, 8);
    check_out("and", 9'h030, 1'b0, 1'b0, 4'd3);
    run_op("or", 8'hF0, 8'h0C, 4, 8);
    check_out("or", 9'h0FC, 1'b0, 1'b0, 4'd4);
    run_op("xor", 8'hFF, 8'h0F, 4, 8);
    check_out("xor", 9'h0F0, 1'b0, 1'b0, 4'd5);
    run_op("not", 8'h0F, 8'h55, 4, 8);
    check_out("not", 9'h0F0, 1'b0, 1'b0, 4'd6);
    run_op("shl", 8'h81, 8'h00, 4, 8);
    check_out("shl", 9'h102, 1'b0, 1'b0, 4'd7);
    run_op("shr", 8'h81, 8'h00, 4, 8);
`ifdef ALU_MUL_EN
    check_out("shr", 9'h040, 1'b0, 1'b0, 4'd8);

    // MUL with operand change and a discarded press while busy
    v0 = valid_count;
    b0 = busy_count;
    number_1 = 8'h0F;
    number_2 = 8'h11;
    @(negedge clk);
    button = 1'b1;
    repeat (4) @(negedge clk);
    button = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    check("mul1_busy_seen", busy, 1'b1);
    number_1 = 8'h00;
    number_2 = 8'h00;
    @(negedge clk);
    button = 1'b1;
    repeat (4) @(negedge clk);
    button = 1'b0;
    repeat (30) @(negedge clk);
    check("mul1_one_valid", valid_count - v0, 1);
    check("mul1_busy_ge8", (busy_count - b0) >= 8, 1);
    check_out("mul1", 9'h0FF, 1'b0, 1'b0, 4'd0);
`else
    check_out("shr", 9'h040, 1'b0, 1'b0, 4'd0);
`endif

    run_op("add2", 8'h01, 8'h01, 4, 8);
    check_out("add2", 9'h002, 1'b0, 1'b0, 4'd1);
    run_op("sub_eq", 8'h0A, 8'h0A, 4, 8);
    check_out("sub_eq", 9'h000, 1'b1, 1'b0, 4'd2);
    run_op("and2", 8'hF0, 8'h3C, 4, 8);
    check_out("and2", 9'h030, 1'b0, 1'b0, 4'd3);

`ifdef ALU_MUL_EN
    for (int k = 3; k < 8; k++) run_op("cyc_a", 8'h81, 8'h01, 4, 8);
    run_op("mul2", 8'hFF, 8'hFF, 4, 16);
    check_out("mul2", 9'h001, 1'b0, 1'b1, 4'd0);
    run_op("add3", 8'h03, 8'h04, 4, 8);
    check_out("add3", 9'h007, 1'b0, 1'b0, 4'd1);
    for (int k = 1; k < 8; k++) run_op("cyc_b", 8'h81, 8'h01, 4, 8);
    check("pre_abort_op_sel", op_sel, 4'd8);
`endif

    // Reset while an operation is in flight
    v0 = valid_count;
    number_1 = 8'h0F;
    number_2 = 8'h11;
    @(negedge clk);
    button = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) button = 1'b0;
      if (busy) break;
    end
    button = 1'b0;
    check("abort_busy_before", busy, 1'b1);
`ifdef ALU_MUL_EN
    repeat (3) @(negedge clk);
`endif
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", valid, 1'b0);
    check("abort_answer", answer, 9'h000);
    check("abort_op_sel", op_sel, 4'd0);
    check("abort_zero", zero, 1'b1);
    check("abort_ovf", ovf, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_late_valid", valid_count - v0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_op_cycler.md
ALU_OP_CYCLER -- requirements
Module: alu_op_cycler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (min 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles before a button level is accepted (min 1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port button  input  1  asynchronous, bouncy push-button, high = pressed.
REQ-006 SHALL have port number_1  input  WIDTH  operand A.
REQ-007 SHALL have port number_2  input  WIDTH  operand B.
REQ-008 SHALL have port answer  output  WIDTH+1  registered result, held until next result.
REQ-009 SHALL have port op_sel  output  4  operation executed by the next press.
REQ-010 SHALL have ports valid, busy, zero, ovf  output  1 each  result strobe, operation in flight, answer==0, MUL overflow.

Function
REQ-011 SHALL pass button through a 2-flop synchroniser before any other use.
REQ-012 SHALL update the debounced level only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any shorter excursion resets the count.
REQ-013 SHALL generate a one-cycle press pulse on each 0->1 transition of the debounced level.
REQ-014 SHALL encode op_sel: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1, 8 MUL (only when configured).
REQ-015 SHALL implement FSM IDLE -> EXEC -> IDLE for ops 0-7 and IDLE -> MUL -> IDLE for op 8.
REQ-016 SHALL, on a press in IDLE (cycle T), capture number_1/number_2 and op_sel into internal registers and enter EXEC/MUL at T+1; busy high from T+1 until valid.
REQ-017 SHALL, for ops 0-7, register answer and pulse valid for exactly one cycle at T+2.
REQ-018 SHALL compute ADD as zero-extended A+B; SUB as A-B in WIDTH+1 bit two's complement (bit WIDTH = borrow); logic/shift ops on WIDTH bits with answer[WIDTH]=0, except SHL where answer[WIDTH]=A[WIDTH-1].
REQ-019 SHALL compute MUL by iterative shift-add, one multiplier bit per cycle, WIDTH cycles in MUL state; answer = low WIDTH+1 bits of product, valid at T+WIDTH+2.
REQ-020 SHALL set ovf=1 with a MUL result when product bits above WIDTH are non-zero, else 0; ovf=0 for all other ops.
REQ-021 SHALL update zero together with answer (1 iff answer==0).
REQ-022 SHALL advance op_sel by one in the same cycle valid asserts, wrapping from the last enabled op to 0.
REQ-023 SHALL discard (not queue) presses occurring while busy=1; operand changes while busy SHALL NOT affect the result.

Reset
REQ-024 SHALL, on reset high at a clock edge, set answer=0, op_sel=0, valid=0, busy=0, zero=1, ovf=0, FSM=IDLE, debounced level=0, debounce count=0, synchroniser flops=0.
REQ-025 SHALL abort any in-flight EXEC/MUL on reset with no valid pulse; reset takes priority over a simultaneous press.

Configuration
REQ-026 SHALL compile op 8 (MUL), MUL state and multiplier datapath only when macro ALU_MUL_EN is defined.
REQ-027 SHALL, with ALU_MUL_EN, wrap op_sel 8 -> 0; without it, wrap 7 -> 0, never produce op_sel 8, and tie ovf to 0.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4)
REQ-028 Reset, A=0x0A, B=0x02, one clean press -> valid pulse, answer=0x00C, zero=0, op_sel 0 -> 1.
REQ-029 Second press with A=0x02, B=0x0A (SUB) -> answer=0x1F8; with A=B=0x0A -> answer=0x000, zero=1.
REQ-030 Button high for 1-3 cycle glitches only -> no valid, op_sel unchanged; 4+ cycle hold -> exactly one press.
REQ-031 Eight presses without ALU_MUL_EN, A=0x81 at SHL -> answer=0x102, SHR -> 0x040, op_sel returns to 0.
REQ-032 ALU_MUL_EN, op 8: 0x0F*0x11 -> answer=0x0FF, ovf=0, busy 8+ cycles; 0xFF*0xFF -> answer=0x001, ovf=1; press during busy ignored.
REQ-033 Reset asserted mid-MUL -> next cycle busy=0, valid=0, answer=0, op_sel=0, no late valid.
